// File: rtl/dmod_win_sched.sv
// Demodulation window sequencer: after a sample trigger it waits for capture, then walks
// each enabled channel's word window over the shared RAM read port and the accumulator.
module dmod_win_sched #(
    parameter int NUM_CH = 12,
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              posedge_sample_trig,
    input  logic [15:0]       cmd_smpl_depth,
    input  logic              pstprc_num_en,
    input  logic [3:0]        Pstprc_num,
    input  logic [14:0]       demoWinstart,
    input  logic [14:0]       demoWinln,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              fifo_full,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic [3:0]        acc_ch,
    output logic              pstprc_fifo_wren,
    output logic              Pstprc_finish,
    output logic              busy,
    output logic              trig_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SCAN    = 3'd2,
        ST_CLR     = 3'd3,
        ST_READ    = 3'd4,
        ST_FLUSH   = 3'd5,
        ST_WRITE   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam logic [3:0] LP_NUM_CH = 4'(NUM_CH);

    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_ch;
    logic [3:0]        w_ch_nx;
    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nx;
    logic [ADDR_W:0]   r_addr;
    logic [ADDR_W:0]   w_addr_nx;

    logic [12:0]       r_tab_start [NUM_CH];
    logic [12:0]       r_tab_len   [NUM_CH];
    logic [12:0]       r_sh_start  [NUM_CH];
    logic [12:0]       r_sh_len    [NUM_CH];
    logic [NUM_CH-1:0] r_sh_en;
    logic [13:0]       r_sh_d;

    logic              w_snap;
    logic              w_sel_en;
    logic [12:0]       w_sel_start;
    logic [12:0]       w_sel_len;
    logic [15:0]       w_s;
    logic [15:0]       w_n_raw;
    logic [15:0]       w_d;
    logic [15:0]       w_n;
    logic              w_unused;

    logic              r_ram_rd_en;
    logic [ADDR_W-1:0] r_ram_rd_addr;
    logic              r_acc_clr;
    logic [3:0]        r_acc_ch;
    logic              r_wren;
    logic              r_finish;
    logic              r_busy;
    logic              r_ovr;
    logic [RD_LAT-1:0] r_rd_pipe;

    // Sub-word sample bits never reach the word-addressed datapath.
    assign w_unused = ^{cmd_smpl_depth[1:0], demoWinstart[1:0], demoWinln[1:0]};

    assign w_snap = (r_state == ST_IDLE) && posedge_sample_trig;

    // Live window table, writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_tab_start[k] <= 13'd0;
                r_tab_len[k]   <= 13'd0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pstprc_num_en && (Pstprc_num == 4'(k))) begin
                    r_tab_start[k] <= demoWinstart[14:2];
                    r_tab_len[k]   <= demoWinln[14:2];
                end else begin
                    r_tab_start[k] <= r_tab_start[k];
                    r_tab_len[k]   <= r_tab_len[k];
                end
            end
        end
    end

    // Shadow copy taken at trigger acceptance; same-cycle config writes land only in the live table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_sh_start[k] <= 13'd0;
                r_sh_len[k]   <= 13'd0;
            end
            r_sh_en <= {NUM_CH{1'b0}};
            r_sh_d  <= 14'd0;
        end else if (w_snap) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_sh_start[k] <= r_tab_start[k];
                r_sh_len[k]   <= r_tab_len[k];
            end
            r_sh_en <= ch_en;
            r_sh_d  <= cmd_smpl_depth[15:2];
        end else begin
            r_sh_en <= r_sh_en;
            r_sh_d  <= r_sh_d;
        end
    end

    // Select the shadow entry of the channel currently being examined.
    always_comb begin
        w_sel_en    = 1'b0;
        w_sel_start = 13'd0;
        w_sel_len   = 13'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sel_en    = (r_ch == 4'(k)) ? r_sh_en[k]    : w_sel_en;
            w_sel_start = (r_ch == 4'(k)) ? r_sh_start[k] : w_sel_start;
            w_sel_len   = (r_ch == 4'(k)) ? r_sh_len[k]   : w_sel_len;
        end
    end

    assign w_s     = {3'd0, w_sel_start};
    assign w_n_raw = {3'd0, w_sel_len};
    assign w_d     = {2'd0, r_sh_d};

    // Clip the word window to the captured depth.
    always_comb begin
        w_n = w_n_raw;
        if (w_s >= w_d) begin
            w_n = 16'd0;
        end else if ((w_s + w_n_raw) > w_d) begin
            w_n = w_d - w_s;
        end else begin
            w_n = w_n_raw;
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_ch_nx    = r_ch;
        w_cnt_nx   = r_cnt;
        w_addr_nx  = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (posedge_sample_trig) begin
                    w_ch_nx = 4'd0;
                    if (cmd_smpl_depth[15:2] == 14'd0) begin
                        w_state_nx = ST_SCAN;
                    end else begin
                        w_state_nx = ST_CAPTURE;
                        w_cnt_nx   = {2'd0, cmd_smpl_depth[15:2]} - 16'd1;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (r_cnt == 16'd0) begin
                    w_state_nx = ST_SCAN;
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            ST_SCAN: begin
                if (r_ch >= LP_NUM_CH) begin
                    w_state_nx = ST_DONE;
                end else if (w_sel_en && (w_n != 16'd0)) begin
                    w_state_nx = ST_CLR;
                    w_addr_nx  = w_s[ADDR_W:0];
                    w_cnt_nx   = w_n - 16'd1;
                end else begin
                    w_ch_nx = r_ch + 4'd1;
                end
            end
            ST_CLR: begin
                w_state_nx = ST_READ;
            end
            ST_READ: begin
                if (r_cnt == 16'd0) begin
                    w_state_nx = ST_FLUSH;
                    w_cnt_nx   = 16'(RD_LAT - 1);
                end else begin
                    w_cnt_nx  = r_cnt - 16'd1;
                    w_addr_nx = r_addr + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 16'd0) begin
                    w_state_nx = ST_WRITE;
                end else begin
                    w_cnt_nx = r_cnt - 16'd1;
                end
            end
            ST_WRITE: begin
                if (!fifo_full) begin
                    w_state_nx = ST_SCAN;
                    w_ch_nx    = r_ch + 4'd1;
                end else begin
                    w_state_nx = ST_WRITE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ch    <= 4'd0;
            r_cnt   <= 16'd0;
            r_addr  <= {(ADDR_W + 1){1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_ch    <= w_ch_nx;
            r_cnt   <= w_cnt_nx;
            r_addr  <= w_addr_nx;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_rd_en   <= 1'b0;
            r_ram_rd_addr <= {ADDR_W{1'b0}};
            r_acc_clr     <= 1'b0;
            r_acc_ch      <= 4'd0;
            r_wren        <= 1'b0;
            r_finish      <= 1'b0;
            r_busy        <= 1'b0;
            r_ovr         <= 1'b0;
        end else begin
            r_ram_rd_en   <= (w_state_nx == ST_READ);
            r_ram_rd_addr <= (w_state_nx == ST_READ) ? w_addr_nx[ADDR_W-1:0] : {ADDR_W{1'b0}};
            r_acc_clr     <= (w_state_nx == ST_CLR);
            r_acc_ch      <= (w_state_nx == ST_CLR) ? w_ch_nx : r_acc_ch;
            r_wren        <= (r_state == ST_WRITE) && !fifo_full;
            r_finish      <= (w_state_nx == ST_DONE);
            r_busy        <= (w_state_nx != ST_IDLE) && (w_state_nx != ST_DONE);
            r_ovr         <= posedge_sample_trig && (r_state != ST_IDLE);
        end
    end

    // Accumulate strobe trails the read strobe by the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pipe <= {RD_LAT{1'b0}};
        end else begin
            r_rd_pipe[0] <= r_ram_rd_en;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rd_pipe[k] <= r_rd_pipe[k-1];
            end
        end
    end

    assign ram_rd_en        = r_ram_rd_en;
    assign ram_rd_addr      = r_ram_rd_addr;
    assign acc_clr          = r_acc_clr;
    assign acc_en           = r_rd_pipe[RD_LAT-1];
    assign acc_ch           = r_acc_ch;
    assign pstprc_fifo_wren = r_wren;
    assign Pstprc_finish    = r_finish;
    assign busy             = r_busy;
    assign trig_overrun     = r_ovr;

endmodule

// File: tb/tb_dmod_win_sched.sv
// Scoreboard bench for dmod_win_sched: expected channel windows and event timing are
// derived from the window rules and pushed at trigger; a monitor pops and compares.
module tb_dmod_win_sched;
    localparam int NUM_CH = 12;
    localparam int ADDR_W = 13;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trig = 1'b0;
    logic [15:0]       cmd_smpl_depth = 16'd0;
    logic              pstprc_num_en = 1'b0;
    logic [3:0]        Pstprc_num = 4'd0;
    logic [14:0]       demoWinstart = 15'd0;
    logic [14:0]       demoWinln = 15'd0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              fifo_full = 1'b0;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              acc_clr;
    logic              acc_en;
    logic [3:0]        acc_ch;
    logic              pstprc_fifo_wren;
    logic              Pstprc_finish;
    logic              busy;
    logic              trig_overrun;

    always #4 clk = ~clk;

    dmod_win_sched #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .posedge_sample_trig(trig), .cmd_smpl_depth(cmd_smpl_depth),
        .pstprc_num_en(pstprc_num_en), .Pstprc_num(Pstprc_num), .demoWinstart(demoWinstart),
        .demoWinln(demoWinln), .ch_en(ch_en), .fifo_full(fifo_full), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .acc_clr(acc_clr), .acc_en(acc_en), .acc_ch(acc_ch),
        .pstprc_fifo_wren(pstprc_fifo_wren), .Pstprc_finish(Pstprc_finish), .busy(busy),
        .trig_overrun(trig_overrun)
    );

    typedef struct {
        bit is_fin;
        int ch;
        int base;
        int n;
        int gap;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  full_at_edge = 1'b0;
    int  m_start [NUM_CH];
    int  m_len   [NUM_CH];
    int  last_ref = 0;
    int  exp_fin = 0;
    int  fin_cnt = 0;
    int  wren_cnt = 0;
    int  ovr_cnt = 0;
    int  exp_ovr = 0;
    bit  full_mode = 1'b0;
    bit  full_force = 1'b0;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        full_at_edge <= fifo_full;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // FIFO-full driver: forced level or random backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (full_mode) fifo_full = ($urandom_range(0, 2) == 0);
            else fifo_full = full_force;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT clears, writes or finishes.
    logic [RD_LAT-1:0] rd_h = '0;
    bit  in_ch = 1'b0;
    bit  saw_full = 1'b0;
    int  rd_cnt = 0;
    int  acc_cnt = 0;
    int  nxt_addr = 0;
    int  clr_cyc = 0;
    ev_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_h  = '0;
            in_ch = 1'b0;
        end else begin
            chk("acc_en_lag", 32'(acc_en), 32'(rd_h[RD_LAT-1]));
            rd_h = {rd_h[RD_LAT-2:0], ram_rd_en};
            if (trig_overrun) ovr_cnt++;
            if (in_ch && full_at_edge) saw_full = 1'b1;
            if (acc_clr) begin
                if (sb.size() == 0 || sb[0].is_fin || in_ch) begin
                    fail_evt("acc_clr");
                end else begin
                    chk("clr_ch", 32'(acc_ch), sb[0].ch);
                    chk("clr_time", cyc, last_ref + sb[0].gap);
                    chk("busy_in_run", 32'(busy), 1);
                    in_ch    = 1'b1;
                    saw_full = 1'b0;
                    rd_cnt   = 0;
                    acc_cnt  = 0;
                    nxt_addr = sb[0].base;
                    clr_cyc  = cyc;
                end
            end
            if (ram_rd_en) begin
                chk("rd_addr", 32'(ram_rd_addr), nxt_addr);
                nxt_addr++;
                rd_cnt++;
            end
            if (acc_en) acc_cnt++;
            if (pstprc_fifo_wren) begin
                wren_cnt++;
                if (!in_ch || sb.size() == 0) begin
                    fail_evt("fifo_wren");
                end else begin
                    cur = sb.pop_front();
                    chk("wren_ch", 32'(acc_ch), cur.ch);
                    chk("read_count", rd_cnt, cur.n);
                    chk("acc_count", acc_cnt, cur.n);
                    chk("wren_while_full", 32'(full_at_edge), 0);
                    if (!saw_full) chk("wren_time", cyc, clr_cyc + cur.n + RD_LAT + 2);
                    last_ref = cyc;
                    in_ch    = 1'b0;
                end
            end
            if (Pstprc_finish) begin
                fin_cnt++;
                if (sb.size() == 0 || !sb[0].is_fin || in_ch) begin
                    fail_evt("finish");
                end else begin
                    chk("fin_time", cyc, last_ref + sb[0].gap);
                    chk("busy_at_fin", 32'(busy), 0);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cfg_write(input int ch, input int st, input int ln);
        @(negedge clk);
        pstprc_num_en = 1'b1;
        Pstprc_num    = ch[3:0];
        demoWinstart  = st[14:0];
        demoWinln     = ln[14:0];
        @(negedge clk);
        pstprc_num_en = 1'b0;
        if (ch < NUM_CH) begin
            m_start[ch] = st;
            m_len[ch]   = ln;
        end
    endtask

    // Issue a trigger and push the expected channel windows from the window rules.
    task automatic fire(input int depth, input bit wcfg, input int wch, input int wst, input int wln);
        int d;
        int prev;
        int s;
        int n;
        ev_t e;
        @(negedge clk);
        cmd_smpl_depth = depth[15:0];
        d        = depth / 4;
        last_ref = cyc + 1 + d;
        prev     = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            s = m_start[k] / 4;
            n = m_len[k] / 4;
            if (s >= d) n = 0;
            else if (s + n > d) n = d - s;
            if (ch_en[k] && n > 0) begin
                e.is_fin = 1'b0; e.ch = k; e.base = s; e.n = n; e.gap = k - prev;
                sb.push_back(e);
                prev = k;
            end
        end
        e.is_fin = 1'b1; e.ch = 0; e.base = 0; e.n = 0; e.gap = NUM_CH - prev;
        sb.push_back(e);
        exp_fin++;
        trig = 1'b1;
        if (wcfg) begin
            pstprc_num_en = 1'b1;
            Pstprc_num    = wch[3:0];
            demoWinstart  = wst[14:0];
            demoWinln     = wln[14:0];
        end
        @(negedge clk);
        trig          = 1'b0;
        pstprc_num_en = 1'b0;
        if (wcfg && wch < NUM_CH) begin
            m_start[wch] = wst;
            m_len[wch]   = wln;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {ram_rd_en, ram_rd_addr, acc_clr, acc_en, acc_ch, pstprc_fifo_wren,
                   Pstprc_finish, busy, trig_overrun}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_outputs_immediate");
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset_outputs("reset_outputs_hold");
        end
        sb.delete();
        exp_fin = fin_cnt;
        for (int k = 0; k < NUM_CH; k++) begin
            m_start[k] = 0;
            m_len[k]   = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (fin_cnt < exp_fin && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (fin_cnt < exp_fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: finishes %0d, expected %0d", fin_cnt, exp_fin);
            do_reset();
        end else begin
            repeat (2) @(negedge clk);
            chk("busy_idle", 32'(busy), 0);
            chk("scoreboard_drained", sb.size(), 0);
        end
    endtask

    task automatic wait_rd(input int budget);
        int i;
        i = 0;
        while (ram_rd_en !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (ram_rd_en !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_read_timeout: ram_rd_en %0d, expected 1", ram_rd_en);
        end
    endtask

    task automatic overrun_pulse();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        exp_ovr++;
    endtask

    initial begin
        int w0;
        int i;
        for (int k = 0; k < NUM_CH; k++) begin
            m_start[k] = 0;
            m_len[k]   = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;

        // Single channel, window clamped by nothing: addresses 1..250.
        ch_en = 12'h001;
        cfg_write(0, 4, 1000);
        fire(1008, 1'b0, 0, 0, 0);
        wait_done(5000);

        // Twelve channels, overrun and ch0 rewrite during busy.
        for (int k = 0; k < NUM_CH; k++) cfg_write(k, k * 80, 80);
        ch_en = 12'hFFF;
        fire(1008, 1'b0, 0, 0, 0);
        wait_rd(2000);
        overrun_pulse();
        cfg_write(0, 0, 40);
        wait_done(5000);
        chk("overrun_count", ovr_cnt, exp_ovr);
        fire(1008, 1'b0, 0, 0, 0);
        wait_done(5000);

        // Clamp and skip; index 13 is out of range and ignored.
        for (int k = 0; k < NUM_CH; k++) cfg_write(k, 0, 0);
        cfg_write(1, 360, 200);
        cfg_write(2, 500, 40);
        cfg_write(3, 16, 16);
        cfg_write(13, 8, 8);
        ch_en = 12'h006;
        fire(400, 1'b0, 0, 0, 0);
        wait_done(3000);

        // FIFO backpressure across the first write.
        cfg_write(0, 0, 40);
        cfg_write(1, 40, 20);
        ch_en      = 12'h003;
        full_force = 1'b1;
        w0         = wren_cnt;
        fire(80, 1'b0, 0, 0, 0);
        wait_rd(500);
        i = 0;
        while (ram_rd_en === 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        repeat (30) @(negedge clk);
        chk("wren_held_while_full", wren_cnt, w0);
        full_force = 1'b0;
        wait_done(1000);
        chk("wren_after_release", wren_cnt, w0 + 2);

        // Trigger and config write in the same cycle: snapshot takes the old entry.
        fire(200, 1'b1, 0, 8, 100);
        wait_done(3000);
        fire(200, 1'b0, 0, 0, 0);
        wait_done(3000);

        // No enabled channels, with zero and non-zero depth.
        ch_en = '0;
        fire(0, 1'b0, 0, 0, 0);
        wait_done(500);
        fire(8, 1'b0, 0, 0, 0);
        wait_done(500);

        // Randomized windows, enables, depths and backpressure.
        full_mode = 1'b1;
        repeat (8) begin
            for (int k = 0; k < NUM_CH; k++) cfg_write(k, $urandom_range(0, 1200), $urandom_range(0, 600));
            ch_en = NUM_CH'($urandom);
            fire($urandom_range(0, 800), 1'b0, 0, 0, 0);
            wait_done(20000);
        end
        full_mode = 1'b0;

        // Reset mid-read aborts the run and clears the table.
        ch_en = 12'hFFF;
        cfg_write(0, 0, 400);
        fire(800, 1'b0, 0, 0, 0);
        wait_rd(1000);
        do_reset();
        ch_en = 12'hFFF;
        fire(400, 1'b0, 0, 0, 0);
        wait_done(1000);

        chk("final_overrun_count", ovr_cnt, exp_ovr);
        chk("final_finish_count", fin_cnt, exp_fin);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmod_win_sched.md
Name: dmod_win_sched

Overview:
- Sequencer for the demodulation segment datapath.
- After each sample trigger, it waits for the I/Q capture RAMs to fill. It then walks every enabled demodulation channel's window in turn, issuing RAM read addresses and accumulator controls.
- After each channel it writes one result into the post-processing FIFO, then signals Pstprc_finish.
- Sits between the trigger/command logic and the shared RAMI/RAMQ read port + demod accumulator.

Parameters:
- NUM_CH, 12, number of demodulation channels (window table entries).
- ADDR_W, 13, RAM read word address width (4 samples per word).
- RD_LAT, 2, clk cycles from ram_rd_en to data valid at the accumulator.

Ports:
- clk  in  1  system clock (125 MHz)
- rst_n  in  1  asynchronous active-low reset
- posedge_sample_trig  in  1  one-cycle trigger pulse
- cmd_smpl_depth  in  16  samples captured per trigger; word depth D = cmd_smpl_depth>>2
- pstprc_num_en  in  1  one-cycle config write strobe
- Pstprc_num  in  4  config channel index (values >= NUM_CH are ignored)
- demoWinstart  in  15  window start, in samples
- demoWinln  in  15  window length, in samples
- ch_en  in  NUM_CH  per-channel enable
- fifo_full  in  1  result FIFO full
- ram_rd_en  out  1  RAM read strobe
- ram_rd_addr  out  ADDR_W  RAM read word address
- acc_clr  out  1  clear accumulator (one cycle)
- acc_en  out  1  accumulate the current RAM word
- acc_ch  out  4  channel currently being processed
- pstprc_fifo_wren  out  1  write the accumulator result to the FIFO
- Pstprc_finish  out  1  one-cycle pulse, all channels done
- busy  out  1  high from trigger acceptance until finish
- trig_overrun  out  1  one-cycle pulse, trigger dropped while busy

Behaviour:
- Reset: all outputs 0, state IDLE. The window table resets to start=0, len=0. Asserting reset mid-operation aborts immediately; no finish or FIFO write is issued.
- Config table write: on pstprc_num_en, table[Pstprc_num] <= {demoWinstart, demoWinln}. Writes are accepted in any state.
- Snapshot: on trigger acceptance, the table, ch_en and D are copied into shadow registers. Config writes during busy therefore affect only the next trigger.
- Word window per channel:
  - S = start>>2, N = len>>2 (low 2 bits discarded).
  - If S >= D, then N = 0.
  - Else if S+N > D, then N = D-S (clamp).
  - Addresses are computed at ADDR_W+1 bits to avoid wrap.
- States:
  - IDLE: trigger -> CAPTURE; busy=1 the next cycle.
  - CAPTURE: count D cycles (D=0 -> zero cycles), then SCAN with ch=0.
  - SCAN: find the lowest ch >= current with ch_en=1 and N>0.
    - If found, go to CLR.
    - If none is left, go to DONE.
    - The search takes one cycle per checked channel.
  - CLR: acc_clr=1 for one cycle, acc_ch=ch -> READ.
  - READ: ram_rd_en=1 with ram_rd_addr = S, S+1, … S+N-1 on consecutive cycles (N cycles) -> FLUSH.
  - FLUSH: wait RD_LAT cycles -> WRITE.
  - WRITE: if fifo_full, hold (wren=0). Otherwise pstprc_fifo_wren=1 for one cycle, then ch+1 -> SCAN.
  - DONE: Pstprc_finish=1 for one cycle, busy=0 -> IDLE.
- acc_en is ram_rd_en delayed exactly RD_LAT cycles, so acc_en is high for exactly N cycles per channel.
- acc_ch is held stable from CLR through WRITE.
- A trigger while busy (including in the DONE cycle) is dropped and trig_overrun pulses the following cycle.
- A trigger in the same cycle as a config write: the snapshot takes the pre-write table.
- With no enabled channels: CAPTURE -> SCAN -> DONE; finish pulses with no FIFO writes.

Test Plan:
- Single channel: depth=1008 (D=252), ch0 start=4 len=1000, ch_en=1, trigger -> 252 capture cycles; acc_clr once; addresses 1..250 contiguous; acc_en high for 250 cycles, starting RD_LAT cycles after the first rd_en; one wren; finish; busy back to 0.
- Twelve channels: ch k start=k*80 len=80, all enabled, depth=1008 -> 12 wrens in order, acc_ch = 0..11, 20 reads each with base address k*20; exactly one finish.
- Clamp/skip: depth=400 (D=100), ch1 start=360 len=200, ch2 start=500 -> ch1 reads addresses 90..99 (10 words); ch2 skipped; disabled channels produce no wren.
- FIFO backpressure: fifo_full held high 30 cycles during WRITE -> wren stays 0 and the state holds; wren is issued exactly once when full drops, and the next channel starts afterward.
- Overrun/config during busy: trigger pulsed mid-READ -> trig_overrun pulse and sequence unaffected. ch0 len rewritten during busy -> the current run uses the old len, the next trigger uses the new len.
- Reset mid-READ: rst_n low for 3 cycles -> all outputs 0 immediately, no finish; the table returns to zero and a subsequent trigger with all len=0 yields finish only.
